row_bias: RTL and testbench



---
 rtl/row_bias.sv | 108 ++++++++++
 tb/tb_row_bias.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/row_bias.sv
// row_bias: per-row one-hot value permutation table.
// After reset the table is shuffled one swap per clock (Fisher-Yates),
// driven by an external pseudo-random word. Once ready, one-hot index
// lookups return the permuted one-hot value one cycle later.
// Build option: define ROW_BIAS_SHUFFLE_EN to build the shuffle; without it
// the table is a fixed identity and ready rises one edge after reset.
module row_bias #(
  parameter int LEN        = 9,
  parameter int RAND_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [RAND_WIDTH-1:0] random,
  input  logic                  update,
  input  logic [LEN-1:0]        rqindex,
  output logic [LEN-1:0]        valtotry,
  output logic                  ready
);

  localparam int KW = $clog2(LEN);

  logic [LEN-1:0] bias [LEN];
  logic [LEN-1:0] sel  [LEN];
  logic [LEN-1:0] hit;

`ifdef ROW_BIAS_SHUFFLE_EN
  logic [KW-1:0] k;
  logic [KW-1:0] j;
  logic          last_step;

  // Swap partner: k plus a random offset into the not-yet-fixed tail.
  always_comb begin
    j         = KW'(32'(k) + (32'(random) % (32'(LEN) - 32'(k))));
    last_step = (k == KW'(LEN - 2));
  end

  // Table: identity on reset, one swap of entries k and j per shuffle step.
  // When j equals k both branches collapse to the same entry, so it holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LEN; i++) begin
        bias[i] <= LEN'(1) << i;
      end
    end else if (!ready) begin
      for (int i = 0; i < LEN; i++) begin
        if (KW'(i) == k) begin
          bias[i] <= bias[j];
        end else if (KW'(i) == j) begin
          bias[i] <= bias[k];
        end
      end
    end
  end

  // Shuffle counter; the step that fixes position LEN-2 finishes the table.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      k     <= '0;
      ready <= 1'b0;
    end else if (!ready) begin
      k <= k + KW'(1);
      if (last_step) begin
        ready <= 1'b1;
      end
    end
  end
`else
  logic unused_random;
  assign unused_random = ^random;

  // Fixed identity table when no shuffle is built.
  for (genvar gi = 0; gi < LEN; gi++) begin : g_ident
    assign bias[gi] = LEN'(1) << gi;
  end

  // Ready one edge after reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready <= 1'b0;
    end else begin
      ready <= 1'b1;
    end
  end
`endif

  // Per-entry select: an index bit passes its table entry through.
  for (genvar gi = 0; gi < LEN; gi++) begin : g_sel
    assign sel[gi] = rqindex[gi] ? bias[gi] : '0;
  end

  // OR of selected entries; multi-hot requests merge, zero request gives zero.
  always_comb begin
    hit = '0;
    for (int i = 0; i < LEN; i++) begin
      hit = hit | sel[i];
    end
  end

  // Lookup register: loads only on accepted requests once the table is final.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valtotry <= '0;
    end else if (ready && update) begin
      valtotry <= hit;
    end
  end

endmodule

// File: tb/tb_row_bias.sv
// tb_row_bias: randomized scoreboard bench for row_bias.
// The reference permutation is computed as a Fisher-Yates shuffle of plain
// integer values from the recorded random words; lookups are predicted from it.
module tb_row_bias;

  localparam int LEN = 9;
  localparam int RW  = 8;
`ifdef ROW_BIAS_SHUFFLE_EN
  localparam int SHUF = LEN - 1;
`else
  localparam int SHUF = 1;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic [RW-1:0]  random;
  logic           update;
  logic [LEN-1:0] rqindex;
  logic [LEN-1:0] valtotry;
  logic           ready;

  row_bias #(.LEN(LEN), .RAND_WIDTH(RW)) dut (
    .clock(clock), .reset(reset), .random(random), .update(update),
    .rqindex(rqindex), .valtotry(valtotry), .ready(ready)
  );

  always #5 clock = ~clock;

  int             n_checks = 0;
  int             n_fail   = 0;
  int             perm [LEN];
  logic [LEN-1:0] exp_q [$];
  logic [LEN-1:0] last_exp = '0;
  logic           upd_s = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [LEN-1:0] model_lookup(input logic [LEN-1:0] idx);
    logic [LEN-1:0] res = '0;
    for (int i = 0; i < LEN; i++) begin
      if (idx[i]) res = res | (LEN'(1) << perm[i]);
    end
    return res;
  endfunction

  // Monitor: note whether an update was sampled at each edge.
  always @(posedge clock) upd_s <= update && !reset;

  // Monitor: compare every sampled lookup against the scoreboard, else check hold.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        last_exp = '0;
      end else if (upd_s) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 32'(exp_q.size()), 1);
        end else begin
          last_exp = exp_q.pop_front();
          chk("lookup", 32'(valtotry), 32'(last_exp));
        end
      end else begin
        chk("hold", 32'(valtotry), 32'(last_exp));
      end
    end
  end

  // Reset, then run the shuffle with a chosen random source.
  // mode: 0 const 0, 1 const 1, 2 LFSR seed 5A, 3 $urandom. abort_at > 0 resets mid-shuffle.
  task automatic run_shuffle(input int mode, input int abort_at, input bit poke);
    int r [LEN];
    logic [7:0] lf = 8'h5A;
    for (int e = 0; e < LEN; e++) begin
      case (mode)
        0: r[e] = 0;
        1: r[e] = 1;
        2: begin r[e] = int'(lf); lf = {lf[6:0], ^(lf & 8'hB8)}; end
        default: r[e] = int'($urandom_range(255));
      endcase
    end
    @(negedge clock);
    update = 1'b0;
    #2 reset = 1'b1;
    #1 chk("rst_ready", 32'(ready), 0);
    chk("rst_val", 32'(valtotry), 0);
    if (abort_at <= 0) begin
      for (int i = 0; i < LEN; i++) perm[i] = i;
`ifdef ROW_BIAS_SHUFFLE_EN
      for (int k = 0; k <= LEN - 2; k++) begin
        int jj = k + (r[k] % (LEN - k));
        int t = perm[k];
        perm[k] = perm[jj];
        perm[jj] = t;
      end
`endif
    end
    @(negedge clock);
    reset = 1'b0;
    random = RW'(r[0]);
    for (int e = 0; e < SHUF; e++) begin
      if (poke) begin
        update = 1'b1;
        rqindex = LEN'($urandom);
        exp_q.push_back('0);
      end else begin
        update = 1'b0;
      end
      @(negedge clock);
      random = RW'(r[e + 1]);
      chk("shuf_ready", 32'(ready), (e == SHUF - 1) ? 1 : 0);
      if (e + 1 == abort_at) begin
        update = 1'b0;
        #2 reset = 1'b1;
        #1 chk("abort_ready", 32'(ready), 0);
        chk("abort_val", 32'(valtotry), 0);
        return;
      end
    end
    update = 1'b0;
  endtask

  task automatic lookup(input logic [LEN-1:0] idx);
    update = 1'b1;
    rqindex = idx;
    exp_q.push_back(model_lookup(idx));
    @(negedge clock);
  endtask

  task automatic idle_gap();
    update = 1'b0;
    rqindex = LEN'($urandom);
    @(negedge clock);
  endtask

  task automatic probe_all();
    for (int i = 0; i < LEN; i++) begin
      lookup(LEN'(1) << i);
      if ($urandom_range(2) == 0) idle_gap();
    end
    idle_gap();
  endtask

  task automatic random_lookups(input int n);
    for (int t = 0; t < n; t++) begin
      lookup(LEN'($urandom));
      if ($urandom_range(3) == 0) idle_gap();
    end
    idle_gap();
  endtask

  initial begin
    reset = 1'b1;
    update = 1'b0;
    rqindex = '0;
    random = '0;
    for (int i = 0; i < LEN; i++) perm[i] = i;
    #1 chk("init_ready", 32'(ready), 0);
    chk("init_val", 32'(valtotry), 0);

    run_shuffle(0, -1, 0);
    probe_all();
    lookup('0);
    idle_gap();

    run_shuffle(1, -1, 1);
    probe_all();
    lookup(9'b000000100);
    lookup('0);
    idle_gap();

    run_shuffle(2, -1, 0);
    probe_all();
    random_lookups(20);

    run_shuffle(3, 4, 1);
    run_shuffle(3, -1, 0);
    probe_all();
    random_lookups(30);

    lookup(LEN'(1));
    update = 1'b0;
    #2 reset = 1'b1;
    #1 chk("midlook_ready", 32'(ready), 0);
    chk("midlook_val", 32'(valtotry), 0);

    run_shuffle(3, -1, 1);
    probe_all();
    random_lookups(10);

    idle_gap();
    idle_gap();
    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
